// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// FSM state encoding, the memory-mapped I/O address and default latencies.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    HOLD    = 2'd3
  } mem_state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  localparam int DEF_RD_LAT = 2;
  localparam int DEF_WR_LAT = 2;

  // Wait counter preload: the pulse fires when the counter reads zero,
  // so a latency of N cycles loads N-1.
  function automatic logic [2:0] lat_cnt(input int lat);
    lat_cnt = 3'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word RAM: 2^ADDR_W x 16, synchronous write, combinational read.
// Ports: clk, i_we, i_addr, i_wdata, o_rdata. Contents survive reset.
module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory responder: latency-modelled RAM with one-shot Mem_RDY.
// Ports: Clk, Reset_n, Mem_OE/Mem_WE requests, ADDR, Data_from_CPU,
//   Switches in; Data_to_CPU, Mem_RDY, HEX_Data, sticky Err out.
// Optional LC3_IO_MAP_EN maps 0xFFFF to Switches (read) / HEX_Data (write).
module mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int WR_LAT = DEF_WR_LAT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_RDY,
  output logic [15:0] HEX_Data,
  output logic        Err
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  mem_state_t  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;

  logic        w_wait;
  logic        w_rdy;
  logic        w_in_range;
  logic        w_is_io;
  logic        w_mem_we;
  logic [15:0] w_mem_rd;
  logic [15:0] w_rd_val;

  assign w_wait = (r_state == RD_WAIT) ||
                  (r_state == WR_WAIT);
  assign w_rdy  = w_wait && (r_cnt == 3'd0);

  assign w_in_range = ({1'b0, r_addr} < DEPTH);

`ifdef LC3_IO_MAP_EN
  assign w_is_io = (r_addr == IO_ADDR);
`else
  assign w_is_io = 1'b0;
`endif

  assign w_mem_we = w_rdy &&
                    (r_state == WR_WAIT) &&
                    w_in_range && !w_is_io;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (Clk),
    .i_we    (w_mem_we),
    .i_addr  (r_addr[ADDR_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rd)
  );

  always_comb begin
    w_rd_val = 16'h0000;
    if (w_is_io)
      w_rd_val = Switches;
    else if (w_in_range)
      w_rd_val = w_mem_rd;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Simultaneous OE+WE is served as a write and flagged.
          if (Mem_WE) begin
            r_state <= WR_WAIT;
            r_cnt   <= lat_cnt(WR_LAT);
            r_addr  <= ADDR;
            r_wdata <= Data_from_CPU;
            if (Mem_OE)
              r_err <= 1'b1;
          end else if (Mem_OE) begin
            r_state <= RD_WAIT;
            r_cnt   <= lat_cnt(RD_LAT);
            r_addr  <= ADDR;
            r_wdata <= Data_from_CPU;
          end
        end
        RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= HOLD;
            r_rdata <= w_rd_val;
          end else if (!Mem_OE) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        WR_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= HOLD;
          end else if (!Mem_WE) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        HOLD: begin
          // Wait for the request to drop so it cannot re-trigger.
          if (!Mem_OE && !Mem_WE)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LC3_IO_MAP_EN
  logic [15:0] r_hex;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_hex <= 16'h0000;
    else if (w_rdy && (r_state == WR_WAIT) && w_is_io)
      r_hex <= r_wdata;
  end

  assign HEX_Data = r_hex;
`else
  assign HEX_Data = 16'h0000;
`endif

  assign Data_to_CPU = r_rdata;
  assign Mem_RDY     = w_rdy;
  assign Err         = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
// Two instances share stimulus: default latencies and RD_LAT=3.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Switches;

  logic [15:0] dout;
  logic        rdy;
  logic [15:0] hex;
  logic        err;

  logic [15:0] dout3;
  logic        rdy3;
  logic [15:0] hex3;
  logic        err3;

  int nchk  = 0;
  int npass = 0;
  int pulses  = 0;
  int pulses3 = 0;

  always #5 Clk = ~Clk;

  mem_responder dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Switches      (Switches),
    .Data_to_CPU   (dout),
    .Mem_RDY       (rdy),
    .HEX_Data      (hex),
    .Err           (err)
  );

  mem_responder #(.RD_LAT(3)) dut3 (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Switches      (Switches),
    .Data_to_CPU   (dout3),
    .Mem_RDY       (rdy3),
    .HEX_Data      (hex3),
    .Err           (err3)
  );

`ifdef LC3_IO_MAP_EN
  localparam logic [15:0] EXP_SW  = 16'h00A5;
  localparam logic [15:0] EXP_HEX = 16'h4321;
`else
  localparam logic [15:0] EXP_SW  = 16'h0000;
  localparam logic [15:0] EXP_HEX = 16'h0000;
`endif

  // Advance one edge, sample 1 time unit later, tally RDY pulses.
  task automatic cyc();
    @(posedge Clk);
    #1;
    pulses  += int'(rdy);
    pulses3 += int'(rdy3);
  endtask

  task automatic do_write(input logic [15:0] a,
                          input logic [15:0] d);
    ADDR = a;
    Data_from_CPU = d;
    Mem_WE = 1'b1;
    repeat (3) cyc();
    Mem_WE = 1'b0;
    cyc();
  endtask

  // Held long enough for the RD_LAT=3 instance too.
  task automatic do_read(input logic [15:0] a);
    ADDR = a;
    Mem_OE = 1'b1;
    repeat (4) cyc();
    Mem_OE = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    ADDR = 16'h0;
    Data_from_CPU = 16'h0;
    Switches = 16'h00A5;
    repeat (2) cyc();
    nchk++;
    if (dout !== 16'h0000)
      $display("FAIL rst_dout got %h exp 0000", dout);
    else npass++;
    nchk++;
    if (rdy !== 1'b0)
      $display("FAIL rst_rdy got %b exp 0", rdy);
    else npass++;
    nchk++;
    if (hex !== 16'h0000)
      $display("FAIL rst_hex got %h exp 0000", hex);
    else npass++;
    nchk++;
    if (err !== 1'b0)
      $display("FAIL rst_err got %b exp 0", err);
    else npass++;
    Reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_write_read();
    pulses = 0;
    do_write(16'h0005, 16'h1234);
    nchk++;
    if (pulses !== 1)
      $display("FAIL wr_pulses got %0d exp 1", pulses);
    else npass++;
    pulses = 0;
    ADDR = 16'h0005;
    Mem_OE = 1'b1;
    cyc();
    nchk++;
    if (rdy !== 1'b0)
      $display("FAIL rd_rdy_k got %b exp 0", rdy);
    else npass++;
    cyc();
    nchk++;
    if (rdy !== 1'b1)
      $display("FAIL rd_rdy_k1 got %b exp 1", rdy);
    else npass++;
    nchk++;
    if (dout !== 16'h0000)
      $display("FAIL rd_early got %h exp 0000", dout);
    else npass++;
    cyc();
    nchk++;
    if (dout !== 16'h1234)
      $display("FAIL rd_data got %h exp 1234", dout);
    else npass++;
    cyc();
    Mem_OE = 1'b0;
    cyc();
    nchk++;
    if (pulses !== 1)
      $display("FAIL rd_pulses got %0d exp 1", pulses);
    else npass++;
  endtask

  task automatic test_hold();
    do_write(16'h0006, 16'h0A0A);
    pulses = 0;
    ADDR = 16'h0006;
    Mem_OE = 1'b1;
    repeat (6) cyc();
    Mem_OE = 1'b0;
    cyc();
    nchk++;
    if (pulses !== 1)
      $display("FAIL hold_pulses got %0d exp 1", pulses);
    else npass++;
    nchk++;
    if (dout !== 16'h0A0A)
      $display("FAIL hold_data got %h exp 0a0a", dout);
    else npass++;
  endtask

  task automatic test_abort();
    do_write(16'h0020, 16'hAAAA);
    do_read(16'h0005);
    pulses3 = 0;
    ADDR = 16'h0020;
    Mem_OE = 1'b1;
    cyc();
    Mem_OE = 1'b0;
    repeat (4) cyc();
    nchk++;
    if (pulses3 !== 0)
      $display("FAIL abort_rdy got %0d exp 0", pulses3);
    else npass++;
    nchk++;
    if (dout3 !== 16'h1234)
      $display("FAIL abort_data got %h exp 1234", dout3);
    else npass++;
    // A fresh read must be accepted at once, proving IDLE.
    Mem_OE = 1'b1;
    repeat (3) cyc();
    nchk++;
    if (rdy3 !== 1'b1)
      $display("FAIL abort_idle got %b exp 1", rdy3);
    else npass++;
    cyc();
    nchk++;
    if (dout3 !== 16'hAAAA)
      $display("FAIL abort_next got %h exp aaaa", dout3);
    else npass++;
    Mem_OE = 1'b0;
    cyc();
  endtask

  task automatic test_err();
    nchk++;
    if (err !== 1'b0)
      $display("FAIL err_pre got %b exp 0", err);
    else npass++;
    ADDR = 16'h0010;
    Data_from_CPU = 16'hBEEF;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    cyc();
    nchk++;
    if (err !== 1'b1)
      $display("FAIL err_set got %b exp 1", err);
    else npass++;
    repeat (3) cyc();
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    cyc();
    do_read(16'h0010);
    nchk++;
    if (dout !== 16'hBEEF)
      $display("FAIL err_ram got %h exp beef", dout);
    else npass++;
    nchk++;
    if (err !== 1'b1)
      $display("FAIL err_sticky got %b exp 1", err);
    else npass++;
  endtask

  task automatic test_out_of_range();
    do_write(16'h0000, 16'h1111);
    pulses = 0;
    do_write(16'h0400, 16'h7777);
    nchk++;
    if (pulses !== 1)
      $display("FAIL oor_pulses got %0d exp 1", pulses);
    else npass++;
    do_read(16'h0400);
    nchk++;
    if (dout !== 16'h0000)
      $display("FAIL oor_read got %h exp 0000", dout);
    else npass++;
    do_read(16'h0000);
    nchk++;
    if (dout !== 16'h1111)
      $display("FAIL oor_alias got %h exp 1111", dout);
    else npass++;
  endtask

  task automatic test_io_map();
    do_write(16'h03FF, 16'h2222);
    do_read(16'hFFFF);
    nchk++;
    if (dout !== EXP_SW)
      $display("FAIL io_read got %h exp %h", dout, EXP_SW);
    else npass++;
    do_write(16'hFFFF, 16'h4321);
    nchk++;
    if (hex !== EXP_HEX)
      $display("FAIL io_hex got %h exp %h", hex, EXP_HEX);
    else npass++;
    do_read(16'h03FF);
    nchk++;
    if (dout !== 16'h2222)
      $display("FAIL io_alias got %h exp 2222", dout);
    else npass++;
  endtask

  task automatic test_capture();
    ADDR = 16'h0030;
    Data_from_CPU = 16'h3333;
    Mem_WE = 1'b1;
    cyc();
    ADDR = 16'h0031;
    Data_from_CPU = 16'h9999;
    repeat (2) cyc();
    Mem_WE = 1'b0;
    cyc();
    do_read(16'h0030);
    nchk++;
    if (dout !== 16'h3333)
      $display("FAIL cap_data got %h exp 3333", dout);
    else npass++;
  endtask

  task automatic test_reset_mid_write();
    do_write(16'h0040, 16'h4444);
    do_read(16'h0040);
    ADDR = 16'h0040;
    Data_from_CPU = 16'h6666;
    Mem_WE = 1'b1;
    cyc();
    #2;
    Reset_n = 1'b0;
    #1;
    nchk++;
    if (dout !== 16'h0000)
      $display("FAIL mid_dout got %h exp 0000", dout);
    else npass++;
    nchk++;
    if (rdy !== 1'b0)
      $display("FAIL mid_rdy got %b exp 0", rdy);
    else npass++;
    nchk++;
    if (err !== 1'b0)
      $display("FAIL mid_err got %b exp 0", err);
    else npass++;
    nchk++;
    if (hex !== 16'h0000)
      $display("FAIL mid_hex got %h exp 0000", hex);
    else npass++;
    Mem_WE = 1'b0;
    repeat (2) cyc();
    Reset_n = 1'b1;
    cyc();
    do_read(16'h0040);
    nchk++;
    if (dout !== 16'h4444)
      $display("FAIL mid_ram got %h exp 4444", dout);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_abort();
    test_err();
    test_out_of_range();
    test_io_map();
    test_capture();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning the backing RAM holds 2^ADDR_W 16-bit words at addresses 0 to 2^ADDR_W-1.
REQ-002 The module SHALL have parameter RD_LAT, default 2, meaning the cycles from read acceptance to the Mem_RDY pulse; legal range 1..7.
REQ-003 The module SHALL have parameter WR_LAT, default 2, meaning the cycles from write acceptance to the Mem_RDY pulse; legal range 1..7.
REQ-004 Port Clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 Port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port Mem_OE, input, 1 bit: active-high read request from the ISDU.
REQ-007 Port Mem_WE, input, 1 bit: active-high write request from the ISDU.
REQ-008 Port ADDR, input, 16 bits: word address (MAR).
REQ-009 Port Data_from_CPU, input, 16 bits: write data (MDR).
REQ-010 Port Switches, input, 16 bits: board switch value.
REQ-011 Port Data_to_CPU, output, 16 bits: registered read data.
REQ-012 Port Mem_RDY, output, 1 bit: one-cycle completion pulse.
REQ-013 Port HEX_Data, output, 16 bits: registered hex-display value.
REQ-014 Port Err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have four states: IDLE, RD_WAIT, WR_WAIT and HOLD.
REQ-016 In IDLE, Mem_WE=1 SHALL move to WR_WAIT, and Mem_OE=1 with Mem_WE=0 SHALL move to RD_WAIT.
REQ-017 On acceptance, ADDR and Data_from_CPU SHALL be captured, and a 3-bit counter SHALL be loaded with RD_LAT-1 or WR_LAT-1.
REQ-018 The counter SHALL decrement each cycle in a WAIT state; at 0, Mem_RDY=1 for that cycle only and the next state SHALL be HOLD.
REQ-019 Read completion SHALL load Data_to_CPU on the same edge Mem_RDY falls; Data_to_CPU SHALL hold its value otherwise.
REQ-020 With RD_LAT=2, a request accepted at edge k SHALL give Mem_RDY high in cycle k+1 and valid Data_to_CPU from edge k+2.
REQ-021 Write completion SHALL write the captured data to RAM at the Mem_RDY edge.
REQ-022 HOLD SHALL return to IDLE only when Mem_OE=0 and Mem_WE=0; a held request SHALL never re-trigger.
REQ-023 If the request deasserts in a WAIT state before the counter reaches 0, the FSM SHALL abort to IDLE with no Mem_RDY, no RAM write and no Data_to_CPU change.
REQ-024 Mem_OE=1 and Mem_WE=1 together in IDLE SHALL be handled as a write and SHALL set Err.
REQ-025 Once set, Err SHALL stay set until reset.
REQ-026 Addresses at or above 2^ADDR_W, other than the mapped address (REQ-031), SHALL read 0 and ignore writes, with normal Mem_RDY timing.
REQ-027 ADDR and data changes during WAIT or HOLD SHALL be ignored; captured values SHALL be used.

Reset
REQ-028 Reset_n=0 SHALL immediately force state IDLE, counter 0, Mem_RDY 0, Data_to_CPU 0x0000, HEX_Data 0x0000 and Err 0.
REQ-029 A reset during a WAIT state SHALL cancel the transaction with no RAM write.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With LC3_IO_MAP_EN defined, address 0xFFFF SHALL read Switches (sampled at completion) and a write to it SHALL load HEX_Data instead of RAM.
REQ-032 Without LC3_IO_MAP_EN, 0xFFFF SHALL follow REQ-026 and HEX_Data SHALL be constant 0x0000.

Structure
REQ-033 Shared package lc3_mem_pkg SHALL hold the FSM state enum, IO_ADDR=16'hFFFF and the default latency constants.
REQ-034 Storage SHALL be a sub-module mem_array: synchronous write, combinational read, parameterised by ADDR_W.

Verification
REQ-035 Write 0x1234 at address 0x0005, then read 0x0005 -> Mem_RDY pulses once per access, Data_to_CPU=0x1234 two edges after read acceptance.
REQ-036 Hold Mem_OE high for 6 cycles -> exactly one Mem_RDY pulse, no second transaction.
REQ-037 Drop Mem_OE after 1 cycle with RD_LAT=3 -> no Mem_RDY, Data_to_CPU unchanged, FSM back in IDLE.
REQ-038 Assert Mem_OE and Mem_WE together at address 0x0010 with data 0xBEEF -> Err=1, RAM[0x0010]=0xBEEF.
REQ-039 With LC3_IO_MAP_EN, Switches=0x00A5: read 0xFFFF -> 0x00A5; write 0x4321 to 0xFFFF -> HEX_Data=0x4321.
REQ-040 Pull Reset_n low mid-WR_WAIT -> no RAM write, all outputs at reset values.
